// File: rtl/jtag_cmd_pkg.sv
// jtag_cmd_pkg: opcodes, FSM states and helpers shared by the JTAG command issuer
package jtag_cmd_pkg;
  localparam int CNT_W = 4;
  localparam int N_CMD = 6;
  typedef enum logic [4:0] {
    OP_WRREG          = 5'h08,
    OP_RDREG          = 5'h09,
    OP_ECR            = 5'h0A,
    OP_BCR            = 5'h0B,
    OP_GENGLOBALPULSE = 5'h0C,
    OP_GENCAL         = 5'h0D
  } opcode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP} state_e;
  function automatic logic [N_CMD-1:0] op_onehot(input opcode_e op);
    return N_CMD'(1) << (op - OP_WRREG);
  endfunction
  function automatic logic is_cmd(input logic [4:0] instr);
    return instr >= OP_WRREG && instr <= OP_GENCAL;
  endfunction
endpackage

// File: rtl/jtag_command_issuer.sv
// jtag_command_issuer: turns Update-DR strobes into timed, gapped one-hot command flags
module jtag_command_issuer
  import jtag_cmd_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       JtagTck,
  input  logic       JtagTrstN,
  input  logic       UpdateDR,
  input  logic [4:0] Instr,
  input  logic       ClearOverrun,
  output logic       WRREG_cmd,
  output logic       RDREG_cmd,
  output logic       ECR_cmd,
  output logic       BCR_cmd,
  output logic       GENGLOBALPULSE_cmd,
  output logic       GENCAL_cmd,
  output logic       CmdBusy,
  output logic       CmdOverrun
);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             pend_v;
  opcode_e          pend_op;
  logic [N_CMD-1:0] flags;
  logic             busy;
  logic             overrun;
  logic             req;
  logic             last;
  logic             drop;
  opcode_e          req_op;
  assign req    = UpdateDR && is_cmd(Instr);
  assign req_op = opcode_e'(Instr);
  assign last   = cnt == '0;
  // the final GAP cycle frees the slot on the same edge, so a request there is never dropped
  assign drop   = req && pend_v && !(state == ST_GAP && last);
  always_ff @(posedge JtagTck or negedge JtagTrstN) begin
    if (!JtagTrstN) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_v  <= 1'b0;
      pend_op <= OP_WRREG;
      flags   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= drop | (overrun & ~ClearOverrun);
      case (state)
        ST_IDLE: if (req) begin
          state <= ST_ASSERT;
          cnt   <= HOLD_LD;
          flags <= op_onehot(req_op);
          busy  <= 1'b1;
        end
        ST_ASSERT: begin
          if (req && !pend_v) begin
            pend_v  <= 1'b1;
            pend_op <= req_op;
          end
          if (last) begin
            state <= ST_GAP;
            cnt   <= GAP_LD;
            flags <= '0;
          end else cnt <= cnt - 1'b1;
        end
        ST_GAP: if (!last) begin
          cnt <= cnt - 1'b1;
          if (req && !pend_v) begin
            pend_v  <= 1'b1;
            pend_op <= req_op;
          end
        end else if (pend_v) begin
          state  <= ST_ASSERT;
          cnt    <= HOLD_LD;
          flags  <= op_onehot(pend_op);
          pend_v <= req;
          if (req) pend_op <= req_op;
        end else if (req) begin
          state <= ST_ASSERT;
          cnt   <= HOLD_LD;
          flags <= op_onehot(req_op);
        end else begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          pend_v <= 1'b0;
          flags  <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end
  assign {GENCAL_cmd, GENGLOBALPULSE_cmd, BCR_cmd, ECR_cmd, RDREG_cmd, WRREG_cmd} = flags;
  assign CmdBusy    = busy;
  assign CmdOverrun = overrun;
endmodule

// File: tb/tb_jtag_command_issuer.sv
// tb_jtag_command_issuer: randomized and directed checks of two issuer configurations against a schedule model
module tb_jtag_command_issuer;
  logic       JtagTck = 1'b0;
  logic       JtagTrstN = 1'b0;
  logic       UpdateDR = 1'b0;
  logic [4:0] Instr = 5'h00;
  logic       ClearOverrun = 1'b0;
  wire  [5:0] f0, f1;
  wire        busy0, busy1, ov0, ov1;
  wire [15:0] obs = {f0, busy0, ov0, f1, busy1, ov1};
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hh[2] = '{2, 1};
  int gg[2] = '{2, 15};
  int s_a[2], s_b[2];
  logic [5:0] o_a[2], o_b[2];
  logic ovm[2];

  always #12 JtagTck = ~JtagTck;

  jtag_command_issuer dut (
    .JtagTck(JtagTck), .JtagTrstN(JtagTrstN), .UpdateDR(UpdateDR), .Instr(Instr),
    .ClearOverrun(ClearOverrun),
    .WRREG_cmd(f0[0]), .RDREG_cmd(f0[1]), .ECR_cmd(f0[2]), .BCR_cmd(f0[3]),
    .GENGLOBALPULSE_cmd(f0[4]), .GENCAL_cmd(f0[5]), .CmdBusy(busy0), .CmdOverrun(ov0)
  );
  jtag_command_issuer #(.HOLD_CYCLES(1), .GAP_CYCLES(15)) dut2 (
    .JtagTck(JtagTck), .JtagTrstN(JtagTrstN), .UpdateDR(UpdateDR), .Instr(Instr),
    .ClearOverrun(ClearOverrun),
    .WRREG_cmd(f1[0]), .RDREG_cmd(f1[1]), .ECR_cmd(f1[2]), .BCR_cmd(f1[3]),
    .GENGLOBALPULSE_cmd(f1[4]), .GENCAL_cmd(f1[5]), .CmdBusy(busy1), .CmdOverrun(ov1)
  );

  // model: remembers the two most recent accepted commands as (start cycle, one-hot flag)
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      s_a[m] = -1000; s_b[m] = -1000; o_a[m] = '0; o_b[m] = '0; ovm[m] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic upd, input logic [4:0] ins, input logic clr);
    for (int m = 0; m < 2; m++) begin
      logic req;
      logic drop;
      int e;
      req = upd && ins >= 5'h08 && ins <= 5'h0D;
      drop = 1'b0;
      e = s_b[m] + hh[m] + gg[m] - 1;
      if (req) begin
        if (s_b[m] >= cyc + 2) drop = 1'b1;
        else begin
          s_a[m] = s_b[m]; o_a[m] = o_b[m];
          s_b[m] = (cyc >= e) ? cyc + 1 : e + 1;
          o_b[m] = 6'b1 << (ins - 5'd8);
        end
      end
      ovm[m] = drop ? 1'b1 : clr ? 1'b0 : ovm[m];
    end
  endtask

  function automatic logic [7:0] exp_one(input int m);
    logic [5:0] fl;
    logic bz;
    fl = '0;
    if (s_a[m] <= cyc && cyc < s_a[m] + hh[m]) fl |= o_a[m];
    if (s_b[m] <= cyc && cyc < s_b[m] + hh[m]) fl |= o_b[m];
    bz = (s_a[m] <= cyc && cyc < s_a[m] + hh[m] + gg[m]) ||
         (s_b[m] <= cyc && cyc < s_b[m] + hh[m] + gg[m]);
    return {fl, bz, ovm[m]};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {exp_one(0), exp_one(1)};
  endfunction

  task automatic step(input logic upd, input logic [4:0] ins, input logic clr);
    UpdateDR = upd; Instr = ins; ClearOverrun = clr;
    @(posedge JtagTck);
    model_edge(upd, ins, clr);
    cyc++;
    @(negedge JtagTck);
    UpdateDR = 1'b0; ClearOverrun = 1'b0;
  endtask

  task automatic settle();
    step(1'b0, 5'h00, 1'b1);
    repeat (45) step(1'b0, 5'h00, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge JtagTck);
    checks++;
    if (obs !== 16'h0) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs, 16'h0); end
    JtagTrstN = 1'b1;
    model_reset();
    step(1'b0, 5'h08, 1'b0);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
  endtask

  task automatic test_single_ecr();
    settle();
    for (int i = 1; i <= 6; i++) begin
      step(i == 1, (i == 1) ? 5'h0A : 5'h00, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL ecr_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      checks++;
      if ({f0, busy0} !== {((i <= 2) ? 6'b000100 : 6'b0), i <= 4}) begin
        errors++; $display("FAIL ecr_timing i=%0d got=%b exp=%b", i, {f0, busy0}, {((i <= 2) ? 6'b000100 : 6'b0), i <= 4});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ef;
    settle();
    for (int i = 1; i <= 8; i++) begin
      step(i <= 2, (i == 1) ? 5'h0D : 5'h09, 1'b0);
      ef = (i <= 2) ? 6'b100000 : (i == 5 || i == 6) ? 6'b000010 : 6'b0;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      checks++;
      if ({f0, ov0} !== {ef, 1'b0}) begin errors++; $display("FAIL b2b_seq i=%0d got=%b exp=%b", i, {f0, ov0}, {ef, 1'b0}); end
    end
  endtask

  task automatic test_overrun();
    logic [1:0] ev;
    settle();
    for (int i = 1; i <= 8; i++) begin
      step(i <= 3, 5'h08, i == 3);
      ev = {(i <= 2 || i == 5 || i == 6), i >= 3};
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL ovr_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      checks++;
      if ({f0[0], ov0} !== ev) begin errors++; $display("FAIL ovr_seq i=%0d got=%b exp=%b", i, {f0[0], ov0}, ev); end
    end
    step(1'b0, 5'h00, 1'b1);
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", ov0); end
  endtask

  task automatic test_ignore();
    settle();
    for (int i = 1; i <= 4; i++) begin
      step(i == 1, (i == 2) ? 5'h08 : 5'h1F, 1'b0);
      checks++;
      if ({f0, busy0, f1, busy1} !== 14'h0) begin errors++; $display("FAIL ignore i=%0d got=%h exp=0", i, {f0, busy0, f1, busy1}); end
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL ignore_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    settle();
    step(1'b1, 5'h0B, 1'b0);
    step(1'b1, 5'h0D, 1'b0);
    checks++;
    if (f0 !== 6'b001000) begin errors++; $display("FAIL rst_mid_pre got=%b exp=%b", f0, 6'b001000); end
    #3 JtagTrstN = 1'b0;
    #1;
    checks++;
    if (obs !== 16'h0) begin errors++; $display("FAIL rst_mid_async got=%h exp=%h", obs, 16'h0); end
    model_reset();
    @(posedge JtagTck);
    cyc++;
    @(negedge JtagTck);
    JtagTrstN = 1'b1;
    step(1'b1, 5'h08, 1'b0);
    checks++;
    if (f0 !== 6'b000001) begin errors++; $display("FAIL rst_first_req got=%b exp=%b", f0, 6'b000001); end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 5'h00, 1'b0);
      checks++;
      if ({f0[5], f1[5]} !== 2'b00 || obs !== exp_vec()) begin
        errors++; $display("FAIL rst_no_gencal cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_last_gap();
    logic [5:0] ef;
    settle();
    for (int i = 1; i <= 40; i++) begin
      step(i == 1 || i == 2 || i == 17, (i == 1) ? 5'h08 : (i == 2) ? 5'h09 : 5'h0A, 1'b0);
      ef = (i == 1) ? 6'b000001 : (i == 17) ? 6'b000010 : (i == 33) ? 6'b000100 : 6'b0;
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL lastgap_model cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
      checks++;
      if ({f1, ov1} !== {ef, 1'b0}) begin errors++; $display("FAIL lastgap_seq i=%0d got=%b exp=%b", i, {f1, ov1}, {ef, 1'b0}); end
    end
  endtask

  task automatic test_random();
    logic upd;
    logic [4:0] ins;
    settle();
    for (int i = 0; i < 300; i++) begin
      upd = ($urandom_range(0, 3) == 0);
      ins = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(8 + $urandom_range(0, 5));
      step(upd, ins, $urandom_range(0, 9) == 0);
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec()); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ecr();
    test_back_to_back();
    test_overrun();
    test_ignore();
    test_reset_mid();
    test_last_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtag_command_issuer.md
JTAG_COMMAND_ISSUER -- requirements
Module: JTAG_COMMAND_ISSUER

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: TCK cycles each command flag stays high; legal range 1..15.
REQ-002 Parameter GAP_CYCLES, default 2: TCK cycles all flags stay low after a command; legal range 1..15.
REQ-003 JtagTck  in  1  JTAG 40 MHz clock; the only clock.
REQ-004 JtagTrstN  in  1  asynchronous active-low reset.
REQ-005 UpdateDR  in  1  single-cycle pulse from the TAP controller in Update-DR state.
REQ-006 Instr  in  5  current IR contents, stable while UpdateDR is high.
REQ-007 ClearOverrun  in  1  synchronous clear of CmdOverrun.
REQ-008 WRREG_cmd, RDREG_cmd, ECR_cmd, BCR_cmd, GENGLOBALPULSE_cmd, GENCAL_cmd  out  1 each  level command flags to the 160 MHz command pulser.
REQ-009 CmdBusy  out  1  high while a command is asserting, in its gap, or pending.
REQ-010 CmdOverrun  out  1  sticky: a request was dropped.

Function
REQ-011 Command request = UpdateDR high and Instr equal to one of the six opcodes WRREG=5'h08, RDREG=5'h09, ECR=5'h0A, BCR=5'h0B, GENGLOBALPULSE=5'h0C, GENCAL=5'h0D.
REQ-012 UpdateDR with any other Instr value shall be ignored, with no state change and no overrun.
REQ-013 FSM states: IDLE, ASSERT, GAP.
REQ-014 IDLE with a request: go to ASSERT; the matching flag goes high on the next TCK edge (latency 1 cycle).
REQ-015 ASSERT: exactly the latched opcode's flag is high for exactly HOLD_CYCLES cycles, then the FSM goes to GAP.
REQ-016 GAP: all flags are low for exactly GAP_CYCLES cycles.
REQ-017 At the end of GAP, a pending command goes to ASSERT with the pending opcode and clears the pending slot; otherwise the FSM goes to IDLE.
REQ-018 A 4-bit down-counter, loaded on state entry, shall time ASSERT and GAP.
REQ-019 The module shall have a one-deep pending slot (valid bit plus opcode).
REQ-020 A request in ASSERT or GAP with the slot empty shall be stored in the slot.
REQ-021 A request with the slot full shall be dropped, and CmdOverrun shall be set.
REQ-022 A request in the final GAP cycle while the slot is full shall behave as follows:
- the slot is consumed;
- the new request is stored;
- no overrun is flagged.
REQ-023 A request in IDLE on the same cycle as the final GAP cycle's transition shall be impossible by construction; IDLE always has an empty slot.
REQ-024 At most one command flag shall be high in any cycle.
REQ-025 Flags shall be driven directly from flops, with no combinational decode on the outputs.
REQ-026 CmdBusy = (state != IDLE) | pending_valid, registered-equivalent with no glitches.
REQ-027 ClearOverrun shall clear CmdOverrun on the next edge; if a set occurs on the same cycle, the set wins.
REQ-028 Back-to-back identical opcodes, for example WRREG in auto-increment mode, shall produce separate high periods separated by at least GAP_CYCLES low cycles, so the downstream edge detector sees every command.

Reset
REQ-029 JtagTrstN low shall force, asynchronously, all of the following:
- state = IDLE;
- counter = 0;
- pending slot empty;
- all six flags = 0;
- CmdBusy = 0;
- CmdOverrun = 0.
REQ-030 Reset asserted mid-ASSERT shall drop the flag immediately, and the command shall be lost without flagging an overrun.
REQ-031 After reset deassertion, the first UpdateDR shall be accepted on the first TCK edge.

Structure
REQ-032 Package JTAG_CMD_PKG shall hold the following; the RTL shall contain no literal opcodes:
- the 5-bit opcode enum for the six instructions;
- the FSM state enum;
- the counter width constant (4).
REQ-033 The block shall be a single module with no sub-modules; flag outputs shall be decoded from the latched opcode into a one-hot register.

Verification
REQ-034 Reset, then UpdateDR with Instr=5'h0A -> ECR_cmd high in cycles 1-2, low in 3-4, CmdBusy low from cycle 5.
REQ-035 GENCAL in cycle 0 and RDREG in cycle 1 -> GENCAL_cmd high in cycles 1-2, gap in 3-4, RDREG_cmd high in cycles 5-6, CmdOverrun=0.
REQ-036 Three WRREG requests in cycles 0, 1, 2 -> two WRREG pulses separated by 2 low cycles, third dropped, CmdOverrun=1; ClearOverrun in the same cycle as a drop leaves it 1.
REQ-037 UpdateDR with Instr=5'h1F, and Instr=5'h08 without UpdateDR -> no flag, CmdBusy=0.
REQ-038 JtagTrstN low during BCR_cmd high, with a pending GENCAL -> all outputs 0 immediately; after release, no GENCAL is ever issued.
REQ-039 With HOLD_CYCLES=1 and GAP_CYCLES=15, a request in the last GAP cycle with the slot full -> no overrun, both commands issued in order.
